dsp_mac_sequencer: RTL and testbench

- Controller that sequences one DSP48A1-style slice as a multiply-accumulate engine.
- Accepts a run length and a valid/ready stream of (a,b) sample pairs.
- Drives the slice's A/B/OPMODE/clock-enable inputs so that P accumulates the sum of a*b.
- Waits for the slice pipeline to drain, then presents the 48-bit result through a valid/ready handshake.
- Slice configuration is fixed: A0REG=0, A1REG=1, B0REG=0, B1REG=1, MREG=1, PREG=1, OPMODREG=1, CARRYOUTREG=1, B_INPUT="DIRECT", CARRYINSEL="OPMOD5".

---
 rtl/dsp_mac_sequencer_if.sv | 41 ++++
 rtl/dsp_mac_sequencer.sv | 171 +++++++++++++++++
 tb/tb_dsp_mac_sequencer.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/dsp_mac_sequencer_if.sv
// Port bundle of dsp_mac_sequencer: run control, sample stream, slice drive and result.
interface dsp_mac_sequencer_if #(
    parameter int LEN_W = 16
);
    logic             start;
    logic [LEN_W-1:0] len;
    logic             busy;
    logic             s_valid;
    logic             s_ready;
    logic [17:0]      s_a;
    logic [17:0]      s_b;
    logic [17:0]      dsp_a;
    logic [17:0]      dsp_b;
    logic [7:0]       dsp_opmode;
    logic             dsp_cea;
    logic             dsp_ceb;
    logic             dsp_cem;
    logic             dsp_cep;
    logic             dsp_ceopmode;
    logic             dsp_cecarryin;
    logic [47:0]      dsp_p;
    logic             dsp_carryout;
    logic             res_valid;
    logic             res_ready;
    logic [47:0]      res_data;
    logic             res_ovf;

    modport slave (
        input  start, len, s_valid, s_a, s_b, dsp_p, dsp_carryout, res_ready,
        output busy, s_ready, dsp_a, dsp_b, dsp_opmode,
               dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin,
               res_valid, res_data, res_ovf
    );

    modport master (
        output start, len, s_valid, s_a, s_b, dsp_p, dsp_carryout, res_ready,
        input  busy, s_ready, dsp_a, dsp_b, dsp_opmode,
               dsp_cea, dsp_ceb, dsp_cem, dsp_cep, dsp_ceopmode, dsp_cecarryin,
               res_valid, res_data, res_ovf
    );
endinterface

// File: rtl/dsp_mac_sequencer.sv
// Sequences one DSP48A1-style slice as a multiply-accumulate engine: streams (a,b) pairs
// into the slice, follows each product through the slice pipeline and returns the 48-bit sum.
module dsp_mac_sequencer #(
    parameter int LEN_W    = 16,
    parameter int PIPE_LAT = 3
) (
    input  logic               clk,
    input  logic               rst,
    dsp_mac_sequencer_if.slave bus
);
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [7:0]          OPM_HOLD  = 8'h08;
    localparam logic [7:0]          OPM_FIRST = 8'h01;
    localparam logic [7:0]          OPM_ACC   = 8'h09;
    localparam logic [LEN_W-1:0]    LEN_ZERO  = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0]    LEN_ONE   = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [PIPE_LAT-2:0] TAG_NONE  = {(PIPE_LAT-1){1'b0}};

    state_t              state_r;
    state_t              state_nxt_s;
    logic [LEN_W-1:0]    remaining_r;
    logic [PIPE_LAT-1:0] tag_v_r;      // bit 0 is stage 1, top bit is the landing stage
    logic                tag_f_r;      // first-product flag of stage 1
    logic                first_r;
    logic [47:0]         res_data_r;
    logic                res_ovf_r;
    logic                ce_s;
    logic                issue_s;
    logic                landing_s;

    assign issue_s   = (state_r == ST_RUN) && (remaining_r != LEN_ZERO) && bus.s_valid;
    // Last product reaching P: nothing younger is still in flight behind it.
    assign landing_s = tag_v_r[PIPE_LAT-1] && (tag_v_r[PIPE_LAT-2:0] == TAG_NONE);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state decode
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (bus.start) begin
                    state_nxt_s = (bus.len != LEN_ZERO) ? ST_RUN : ST_DONE;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (issue_s && (remaining_r == LEN_ONE)) begin
                    state_nxt_s = ST_DRAIN;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_DRAIN: begin
                if (landing_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_DRAIN;
                end
            end
            ST_DONE: begin
                if (bus.res_ready) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_DONE;
                end
            end
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Run counter, tag pipe, result and sticky carry capture
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            remaining_r <= LEN_ZERO;
            tag_v_r     <= {PIPE_LAT{1'b0}};
            tag_f_r     <= 1'b0;
            first_r     <= 1'b0;
            res_data_r  <= 48'd0;
            res_ovf_r   <= 1'b0;
        end else begin
            tag_v_r <= {tag_v_r[PIPE_LAT-2:0], issue_s};
            tag_f_r <= issue_s && first_r;
            case (state_r)
                ST_IDLE: begin
                    if (bus.start) begin
                        remaining_r <= bus.len;
                        first_r     <= 1'b1;
                        res_data_r  <= 48'd0;
                        res_ovf_r   <= 1'b0;
                    end
                end
                ST_RUN: begin
                    if (issue_s) begin
                        remaining_r <= remaining_r - LEN_ONE;
                        first_r     <= 1'b0;
                    end
                    if (tag_v_r[PIPE_LAT-1]) begin
                        res_ovf_r <= res_ovf_r | bus.dsp_carryout;
                    end
                end
                ST_DRAIN: begin
                    if (tag_v_r[PIPE_LAT-1]) begin
                        res_ovf_r <= res_ovf_r | bus.dsp_carryout;
                    end
                    if (landing_s) begin
                        res_data_r <= bus.dsp_p;
                    end
                end
                default: begin
                    remaining_r <= remaining_r;
                end
            endcase
        end
    end

    // Output decode from state and tag stage 1
    always_comb begin
        bus.busy      = 1'b1;
        bus.s_ready   = 1'b0;
        bus.res_valid = 1'b0;
        ce_s          = 1'b0;
        case (state_r)
            ST_IDLE:  bus.busy = 1'b0;
            ST_RUN: begin
                ce_s        = 1'b1;
                bus.s_ready = (remaining_r != LEN_ZERO);
            end
            ST_DRAIN: ce_s = 1'b1;
            ST_DONE:  bus.res_valid = 1'b1;
            default:  bus.busy = 1'b0;
        endcase
        if (issue_s) begin
            bus.dsp_a = bus.s_a;
            bus.dsp_b = bus.s_b;
        end else begin
            bus.dsp_a = 18'd0;
            bus.dsp_b = 18'd0;
        end
        if (!tag_v_r[0]) begin
            bus.dsp_opmode = OPM_HOLD;
        end else if (tag_f_r) begin
            bus.dsp_opmode = OPM_FIRST;
        end else begin
            bus.dsp_opmode = OPM_ACC;
        end
    end

    assign bus.dsp_cea       = ce_s;
    assign bus.dsp_ceb       = ce_s;
    assign bus.dsp_cem       = ce_s;
    assign bus.dsp_cep       = ce_s;
    assign bus.dsp_ceopmode  = ce_s;
    assign bus.dsp_cecarryin = ce_s;
    assign bus.res_data      = res_data_r;
    assign bus.res_ovf       = res_ovf_r;
endmodule

// File: tb/tb_dsp_mac_sequencer.sv
// Bench for dsp_mac_sequencer: a behavioural DSP48A1 slice (A1/B1/M/P/OPMODE registers),
// table-driven runs with a result scoreboard, and hand-written reset / start-ignore sequences.
module tb_dsp_mac_sequencer;
    localparam int LEN_W = 16;

    typedef struct {
        int              len;
        logic [4:0][17:0] a;
        logic [4:0][17:0] b;
        int              gap;
        int              hold;
        bit              poke;
        logic [47:0]     exp_data;
        logic            exp_ovf;
        int              exp_lat;
    } vec_t;

    typedef struct packed {
        logic [47:0] d;
        logic        o;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;
    exp_t sb_q[$];
    vec_t vecs[8];
    vec_t vr;

    dsp_mac_sequencer_if #(.LEN_W(LEN_W)) bus ();

    dsp_mac_sequencer #(.LEN_W(LEN_W), .PIPE_LAT(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural slice: signed 18x18 multiply, X=M / Z=P post-adder with carry out
    logic [17:0] sl_a1 = 18'd0;
    logic [17:0] sl_b1 = 18'd0;
    logic [35:0] sl_m = 36'd0;
    logic [7:0]  sl_opm = 8'h00;
    logic [47:0] sl_p = 48'd0;
    logic        sl_co = 1'b0;
    logic [48:0] sl_sum;

    function automatic logic [35:0] mul18(input logic [17:0] a, input logic [17:0] b);
        logic signed [35:0] ea, eb, pr;
        ea = {{18{a[17]}}, a};
        eb = {{18{b[17]}}, b};
        pr = ea * eb;
        return pr;
    endfunction

    function automatic logic [48:0] post_add(input logic [7:0] opm, input logic [35:0] m,
                                             input logic [47:0] p);
        logic [47:0] x, z;
        x = (opm[1:0] == 2'b01) ? {{12{m[35]}}, m} : 48'd0;
        z = (opm[3:2] == 2'b10) ? p : 48'd0;
        return {1'b0, z} + {1'b0, x};
    endfunction

    assign sl_sum           = post_add(sl_opm, sl_m, sl_p);
    assign bus.dsp_p        = sl_p;
    assign bus.dsp_carryout = sl_co;

    always @(posedge clk) begin
        if (bus.dsp_cea) sl_a1 <= bus.dsp_a;
        if (bus.dsp_ceb) sl_b1 <= bus.dsp_b;
        if (bus.dsp_cem) sl_m <= mul18(sl_a1, sl_b1);
        if (bus.dsp_ceopmode) sl_opm <= bus.dsp_opmode;
        if (bus.dsp_cep) sl_p <= sl_sum[47:0];
        if (bus.dsp_cecarryin) sl_co <= sl_sum[48];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %0h required %0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // Handshake history: expected OPMODE follows the previous cycle's issue
    logic hs_v, hs_f, tb_first;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            hs_v <= 1'b0;
            hs_f <= 1'b0;
            tb_first <= 1'b0;
        end else begin
            hs_v <= bus.s_valid && bus.s_ready;
            hs_f <= bus.s_valid && bus.s_ready && tb_first;
            if (bus.start && !bus.busy) tb_first <= 1'b1;
            else if (bus.s_valid && bus.s_ready) tb_first <= 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("opmode", bus.dsp_opmode, !hs_v ? 8'h08 : (hs_f ? 8'h01 : 8'h09));
            chk("ce", {bus.dsp_cea, bus.dsp_ceb, bus.dsp_cem, bus.dsp_cep, bus.dsp_ceopmode,
                       bus.dsp_cecarryin}, {6{bus.busy && !bus.res_valid}});
        end
    end

    task automatic check_reset_vals();
        chk("rst_busy", bus.busy, 1'b0);
        chk("rst_s_ready", bus.s_ready, 1'b0);
        chk("rst_ce", {bus.dsp_cea, bus.dsp_ceb, bus.dsp_cem, bus.dsp_cep, bus.dsp_ceopmode,
                       bus.dsp_cecarryin}, 6'd0);
        chk("rst_dsp_a", bus.dsp_a, 18'd0);
        chk("rst_dsp_b", bus.dsp_b, 18'd0);
        chk("rst_opmode", bus.dsp_opmode, 8'h08);
        chk("rst_res_valid", bus.res_valid, 1'b0);
        chk("rst_res_data", bus.res_data, 48'd0);
        chk("rst_res_ovf", bus.res_ovf, 1'b0);
    endtask

    task automatic send_pair(input logic [17:0] a, input logic [17:0] b, output int icyc);
        int budget = 0;
        bus.s_valid = 1'b1;
        bus.s_a = a;
        bus.s_b = b;
        while (!bus.s_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        chk("s_ready_seen", bus.s_ready, 1'b1);
        icyc = cyc;
        @(negedge clk);
        bus.s_valid = 1'b0;
        bus.s_a = 18'd0;
        bus.s_b = 18'd0;
    endtask

    task automatic collect(input int hold, input int ref_cyc, input int exp_lat, input bit poke);
        int   budget = 0;
        exp_t e = '0;
        while (!bus.res_valid && budget < 100) begin
            @(negedge clk);
            budget++;
        end
        chk("res_valid_seen", bus.res_valid, 1'b1);
        chk("latency", cyc - ref_cyc, exp_lat);
        chk("sb_depth", sb_q.size(), 1);
        if (sb_q.size() != 0) e = sb_q.pop_front();
        chk("res_data", bus.res_data, e.d);
        chk("res_ovf", bus.res_ovf, e.o);
        if (poke) begin
            bus.start = 1'b1;
            bus.len = 16'd9;
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            chk("hold_valid", bus.res_valid, 1'b1);
            chk("hold_data", bus.res_data, e.d);
            chk("hold_ovf", bus.res_ovf, e.o);
        end
        bus.start = 1'b0;
        bus.res_ready = 1'b1;
        @(negedge clk);
        bus.res_ready = 1'b0;
        chk("idle_valid", bus.res_valid, 1'b0);
        chk("idle_busy", bus.busy, 1'b0);
    endtask

    task automatic do_run(input vec_t v);
        int ic0, ic;
        sb_q.push_back({v.exp_data, v.exp_ovf});
        @(negedge clk);
        bus.start = 1'b1;
        bus.len = v.len[LEN_W-1:0];
        ic0 = cyc;
        @(negedge clk);
        bus.start = 1'b0;
        for (int k = 0; k < v.len; k++) begin
            if (v.poke && k == 1) begin
                bus.start = 1'b1;
                bus.len = 16'd7;
            end
            send_pair(v.a[k], v.b[k], ic);
            bus.start = 1'b0;
            if (k == 0) begin
                ic0 = ic;
                repeat (v.gap) @(negedge clk);
            end
        end
        collect(v.hold, ic0, v.exp_lat, v.poke);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ic;
        rst = 1'b1;
        bus.start = 1'b0;
        bus.len = 16'd0;
        bus.s_valid = 1'b0;
        bus.s_a = 18'd0;
        bus.s_b = 18'd0;
        bus.res_ready = 1'b0;

        vecs[0] = '{len: 4, a: {18'd0, 18'd7, 18'd5, 18'd3, 18'd1},
                    b: {18'd0, 18'd8, 18'd6, 18'd4, 18'd2},
                    gap: 0, hold: 0, poke: 1'b0, exp_data: 48'd100, exp_ovf: 1'b0, exp_lat: 7};
        vecs[1] = '{len: 3, a: {18'd0, 18'd0, 18'd6, 18'd4, 18'd2},
                    b: {18'd0, 18'd0, 18'd7, 18'd5, 18'd3},
                    gap: 2, hold: 0, poke: 1'b0, exp_data: 48'd68, exp_ovf: 1'b0, exp_lat: 8};
        vecs[2] = '{len: 3, a: {18'd0, 18'd0, 18'd6, 18'd4, 18'd2},
                    b: {18'd0, 18'd0, 18'd7, 18'd5, 18'd3},
                    gap: 0, hold: 0, poke: 1'b0, exp_data: 48'd68, exp_ovf: 1'b0, exp_lat: 6};
        vecs[3] = '{len: 0, a: '0, b: '0,
                    gap: 0, hold: 1, poke: 1'b0, exp_data: 48'd0, exp_ovf: 1'b0, exp_lat: 1};
        vecs[4] = '{len: 2, a: {18'd0, 18'd0, 18'd0, 18'h3FFFF, 18'h3FFFF},
                    b: {18'd0, 18'd0, 18'd0, 18'h3FFFF, 18'h3FFFF},
                    gap: 0, hold: 5, poke: 1'b0, exp_data: 48'd2, exp_ovf: 1'b0, exp_lat: 5};
        vecs[5] = '{len: 2, a: {18'd0, 18'd0, 18'd0, 18'h3FFFF, 18'd1},
                    b: {18'd0, 18'd0, 18'd0, 18'd1, 18'd1},
                    gap: 0, hold: 0, poke: 1'b0, exp_data: 48'd0, exp_ovf: 1'b1, exp_lat: 5};
        vecs[6] = '{len: 3, a: {18'd0, 18'd0, 18'h1FFFF, 18'h20000, 18'h1FFFF},
                    b: {18'd0, 18'd0, 18'h20000, 18'h20000, 18'h1FFFF},
                    gap: 0, hold: 0, poke: 1'b0, exp_data: 48'd17179738113, exp_ovf: 1'b1,
                    exp_lat: 6};
        vecs[7] = '{len: 2, a: {18'd0, 18'd0, 18'd0, 18'd6, 18'd5},
                    b: {18'd0, 18'd0, 18'd0, 18'd6, 18'd5},
                    gap: 0, hold: 2, poke: 1'b1, exp_data: 48'd61, exp_ovf: 1'b0, exp_lat: 5};

        repeat (2) @(negedge clk);
        check_reset_vals();
        rst = 1'b0;

        for (int i = 0; i < 8; i++) do_run(vecs[i]);

        // Reset in the middle of a run, after two of five issues
        @(negedge clk);
        bus.start = 1'b1;
        bus.len = 16'd5;
        @(negedge clk);
        bus.start = 1'b0;
        send_pair(18'd11, 18'd12, ic);
        send_pair(18'd13, 18'd14, ic);
        #2 rst = 1'b1;
        #1 check_reset_vals();
        @(negedge clk);
        rst = 1'b0;

        vr = '{len: 1, a: {18'd0, 18'd0, 18'd0, 18'd0, 18'd9},
               b: {18'd0, 18'd0, 18'd0, 18'd0, 18'd9},
               gap: 0, hold: 0, poke: 1'b0, exp_data: 48'd81, exp_ovf: 1'b0, exp_lat: 4};
        do_run(vr);

        chk("sb_drained", sb_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
